command_word_emit: RTL and testbench
====================================

// Module: command_word_emit
// PURPOSE
//  Encoder and writer for the 32-bit command word: the inverse of the command-word field decode.
//  Accepts per-field command descriptions over a valid/ready handshake and packs them into words.
//  Buffers the packed words in a small FIFO, then writes them to program memory at an auto-incrementing address.
//  Sits between the program loader / debug port and the instruction memory write bus.
// PARAMETERS
//  FIFO_DEPTH  4   packed-word buffer entries; power of two, >=2
//  ADDR_WIDTH  16  program memory word-address width; address wraps at 2**ADDR_WIDTH
// PORTS
//  clk            in   1   sole clock; all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  in_valid       in   1   field set valid
//  in_ready       out  1   field set accepted when in_valid&&in_ready at clk edge
//  reg_s1/s0/d/cnd in  3 each  register numbers (`CMD_BITS_PER_REG0+1)
//  ptr_s1/s0/d/cnd in  1 each  pointer (indirect) flags
//  flg_s1/s0/d/cnd in  2 each  per-operand flag pairs
//  is_cond        in   1   conditional execution
//  is_cond_true   in   1   condition polarity
//  cmd_code       in   4   opcode (`CMD_BITS_PER_CMD_CODE0+1)
//  addr_load      in   1   load write pointer from addr_base
//  addr_base      in   ADDR_WIDTH  new write pointer
//  mem_wr         out  1   write request, held until mem_ack
//  mem_addr       out  ADDR_WIDTH  write address
//  mem_data       out  32  packed command word
//  mem_ack        in   1   memory accepted write this cycle
//  busy           out  1   FIFO non-empty or write in flight
//  words_written  out  ADDR_WIDTH  count of acked writes, wraps
//  err            out  1   sticky illegal-encoding flag (CMD_EMIT_CHECK_EN only, else tied 0)
//  err_clr        in   1   clears err
// BEHAVIOUR
//  Packing: [2:0]reg_s1 [3]ptr_s1 [6:4]reg_s0 [7]ptr_s0 [10:8]reg_d [11]ptr_d [14:12]reg_cnd
//   [15]ptr_cnd [17:16]flg_s1 [19:18]flg_s0 [21:20]flg_d [23:22]flg_cnd [24]is_cond
//   [25]is_cond_true [27:26]=2'b00 [31:28]cmd_code. Packing is combinational into the FIFO write port.
//  Reset: in_ready=1 (FIFO empty), mem_wr=0, mem_addr=0, mem_data=0, busy=0, words_written=0, err=0; FSM=W_IDLE.
//  in_ready = FIFO not full; registered from count, so it never depends on same-cycle mem_ack.
//  FSM W_IDLE: if FIFO non-empty, next edge load mem_data<=head and mem_addr<=wptr, set mem_wr=1, go W_REQ.
//   A word accepted at edge N therefore shows mem_wr=1 after edge N+1.
//  FSM W_REQ: mem_wr, mem_addr and mem_data stay stable until mem_ack.
//   On the ack edge: pop, wptr++, words_written++.
//   If another entry remains, stay in W_REQ with the next word and addr (1 word/cycle under continuous ack).
//   Otherwise mem_wr=0 and go W_IDLE.
//  addr_load is honoured only in W_IDLE (wptr<=addr_base, takes effect for the next write).
//   In W_REQ it is ignored.
//  Simultaneous push+pop on the same edge: count unchanged. A push when full cannot occur because in_ready is low.
//  Address wrap: wptr of all ones plus 1 gives 0; words_written wraps likewise.
//  busy = (count!=0) || mem_wr.
//  Asynchronous reset mid-write drops the in-flight word and all FIFO contents; no partial state survives.
// CONFIGURATION
//  CMD_EMIT_CHECK_EN defined: a field set is illegal if is_cond_true=1 with is_cond=0.
//   It is also illegal if is_cond=1 while ptr_cnd=0 and reg_cnd=0.
//   An illegal set is still handshaken (in_ready honoured) but not pushed, and err is set.
//   err stays set until err_clr; err_clr wins over a same-cycle new error.
//  CMD_EMIT_CHECK_EN undefined: every field set is packed as given; err is tied 0 and err_clr is ignored.
// STRUCTURE
//  sizes.v gains field bit-position constants (CMD_POS_S1, ... CMD_POS_CODE) and CMD_WORD_BITS=32.
//   The decoder and this block share those constants.
//  Sub-module cmd_emit_fifo: synchronous FIFO, 32 bits wide, FIFO_DEPTH entries, count output, async active-low reset.
//  Top level holds the packer, the writer FSM, wptr and words_written.
// TESTING
//  1. Single word: reg_s1=1, reg_s0=2, reg_d=3, cmd_code=4'hA, all else 0, addr_base=0x0100, mem_ack the next cycle.
//     Expect mem_data=0xA0000321, mem_addr=0x0100, mem_wr high for exactly 1 cycle, words_written=1.
//  2. Stall: hold mem_ack=0 for 5 cycles while 5 sets are offered.
//     Expect in_ready=0 after 4 accepted and mem_wr/addr/data stable; then ack every cycle.
//     Expect 5 consecutive writes at 0x0100..0x0104.
//  3. Wrap: addr_base=0xFFFF, write 2 words -> addresses 0xFFFF then 0x0000.
//  4. All-ones fields (3'h7, ptr=1, flg=2'b11, is_cond=1, is_cond_true=1, cmd_code=4'hF) -> mem_data=0xF3FFFFFF.
//  5. Reset: assert rst_n=0 while mem_wr=1 with 2 entries queued.
//     Expect mem_wr=0, busy=0 and in_ready=1 immediately; no further writes after release.
//  6. CHECK_EN: is_cond=0, is_cond_true=1.
//     Expect no mem_wr, err=1 until err_clr pulse; without the macro, expect the word written with bit25=1.

Source files
------------

// File: rtl/command_word_emit_pkg.sv
// -----------------------------------------------------------------------------
// command_word_emit_pkg
// Shared definitions for the 32-bit command word. Holds the field bit
// positions, which the decoder also uses, plus the field-set struct. It also
// provides the packing helper and the encoding-legality helper.
// -----------------------------------------------------------------------------
package command_word_emit_pkg;

  localparam int CMD_WORD_BITS      = 32;
  localparam int CMD_BITS_PER_REG   = 3;
  localparam int CMD_BITS_PER_FLG   = 2;
  localparam int CMD_BITS_PER_CODE  = 4;

  // Operand slots: register number at POS, pointer flag at POS+CMD_BITS_PER_REG.
  localparam int CMD_POS_S1         = 0;
  localparam int CMD_POS_S0         = 4;
  localparam int CMD_POS_D          = 8;
  localparam int CMD_POS_CND        = 12;
  localparam int CMD_POS_FLG_S1     = 16;
  localparam int CMD_POS_FLG_S0     = 18;
  localparam int CMD_POS_FLG_D      = 20;
  localparam int CMD_POS_FLG_CND    = 22;
  localparam int CMD_POS_COND       = 24;
  localparam int CMD_POS_COND_TRUE  = 25;
  localparam int CMD_POS_RSVD       = 26;   // two reserved bits, always 0
  localparam int CMD_POS_CODE       = 28;

  typedef logic [CMD_WORD_BITS-1:0] cmd_word_t;

  typedef struct packed {
    logic [CMD_BITS_PER_REG-1:0]  reg_s1;
    logic [CMD_BITS_PER_REG-1:0]  reg_s0;
    logic [CMD_BITS_PER_REG-1:0]  reg_d;
    logic [CMD_BITS_PER_REG-1:0]  reg_cnd;
    logic                         ptr_s1;
    logic                         ptr_s0;
    logic                         ptr_d;
    logic                         ptr_cnd;
    logic [CMD_BITS_PER_FLG-1:0]  flg_s1;
    logic [CMD_BITS_PER_FLG-1:0]  flg_s0;
    logic [CMD_BITS_PER_FLG-1:0]  flg_d;
    logic [CMD_BITS_PER_FLG-1:0]  flg_cnd;
    logic                         is_cond;
    logic                         is_cond_true;
    logic [CMD_BITS_PER_CODE-1:0] cmd_code;
  } cmd_fields_t;

  // Place every field at its shared bit position; reserved bits stay zero.
  function automatic cmd_word_t pack_cmd(input cmd_fields_t f);
    cmd_word_t w;
    w = '0;
    w[CMD_POS_S1  +: CMD_BITS_PER_REG]          = f.reg_s1;
    w[CMD_POS_S1  +  CMD_BITS_PER_REG]          = f.ptr_s1;
    w[CMD_POS_S0  +: CMD_BITS_PER_REG]          = f.reg_s0;
    w[CMD_POS_S0  +  CMD_BITS_PER_REG]          = f.ptr_s0;
    w[CMD_POS_D   +: CMD_BITS_PER_REG]          = f.reg_d;
    w[CMD_POS_D   +  CMD_BITS_PER_REG]          = f.ptr_d;
    w[CMD_POS_CND +: CMD_BITS_PER_REG]          = f.reg_cnd;
    w[CMD_POS_CND +  CMD_BITS_PER_REG]          = f.ptr_cnd;
    w[CMD_POS_FLG_S1  +: CMD_BITS_PER_FLG]      = f.flg_s1;
    w[CMD_POS_FLG_S0  +: CMD_BITS_PER_FLG]      = f.flg_s0;
    w[CMD_POS_FLG_D   +: CMD_BITS_PER_FLG]      = f.flg_d;
    w[CMD_POS_FLG_CND +: CMD_BITS_PER_FLG]      = f.flg_cnd;
    w[CMD_POS_COND]                             = f.is_cond;
    w[CMD_POS_COND_TRUE]                        = f.is_cond_true;
    w[CMD_POS_CODE +: CMD_BITS_PER_CODE]        = f.cmd_code;
    return w;
  endfunction

  // A polarity without a condition is meaningless. A condition on the hardwired
  // register 0 with no indirection is also meaningless.
  function automatic logic cmd_is_illegal(input cmd_fields_t f);
    return (f.is_cond_true && !f.is_cond) ||
           (f.is_cond && !f.ptr_cnd && (f.reg_cnd == '0));
  endfunction

endpackage

// File: rtl/command_word_emit_if.sv
// -----------------------------------------------------------------------------
// command_word_emit_if
// Bundles the field-set handshake, the program-memory write bus and the
// status/error signals of command_word_emit.
//   slave  : the emitter's view (command_word_emit)
//   master : the loader / memory side's view
// Field set : in_valid, in_ready, fields (cmd_fields_t), addr_load, addr_base
// Memory bus: mem_wr, mem_addr, mem_data, mem_ack
// Status    : busy, words_written, err, err_clr
// -----------------------------------------------------------------------------
interface command_word_emit_if #(
  parameter int ADDR_WIDTH = 16
);
  import command_word_emit_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  cmd_fields_t           fields;
  logic                  addr_load;
  logic [ADDR_WIDTH-1:0] addr_base;

  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  cmd_word_t             mem_data;
  logic                  mem_ack;

  logic                  busy;
  logic [ADDR_WIDTH-1:0] words_written;
  logic                  err;
  logic                  err_clr;

  modport slave (
    input  in_valid, fields, addr_load, addr_base, mem_ack, err_clr,
    output in_ready, mem_wr, mem_addr, mem_data, busy, words_written, err
  );

  modport master (
    output in_valid, fields, addr_load, addr_base, mem_ack, err_clr,
    input  in_ready, mem_wr, mem_addr, mem_data, busy, words_written, err
  );

endinterface

// File: rtl/command_word_emit_fifo.sv
// -----------------------------------------------------------------------------
// cmd_emit_fifo
// Synchronous FIFO holding packed command words until the writer drains them.
// The head entry is exposed, and so is the entry behind it. This lets the
// writer advance to the next word on the same edge that retires the head.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_push      write i_data (caller guarantees not full)
//   i_pop       retire the head (caller guarantees not empty)
//   o_head      oldest entry
//   o_next      entry behind the head (valid when o_count >= 2)
//   o_count     number of entries held
// -----------------------------------------------------------------------------
module cmd_emit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head,
  output logic [WIDTH-1:0]       o_next,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;

  // NOTE: storage has no reset; entries are only read after being written, so
  // clearing them would add reset fan-out with no functional effect.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;   // idle, or push and pop cancel out
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_next  = r_mem[r_rd_ptr + AW'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/command_word_emit.sv
// -----------------------------------------------------------------------------
// command_word_emit
// Packs per-field command descriptions into 32-bit command words and buffers
// them in a small FIFO. It then writes them to program memory at an
// auto-incrementing word address.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         command_word_emit_if.slave: field-set handshake, memory write
//               bus (held until mem_ack), busy, words_written, err/err_clr
// Optional feature: define CMD_EMIT_CHECK_EN to reject illegal encodings.
// Illegal sets are still handshaken but dropped, and they raise sticky err.
// Without it, err is tied 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module command_word_emit
  import command_word_emit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  command_word_emit_if.slave  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_REQ  = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_words;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  cmd_word_t             r_mem_data;

  logic [CW-1:0]         w_count;
  cmd_word_t             w_head;
  cmd_word_t             w_next;
  cmd_word_t             w_packed;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_launch_addr;

  // in_ready depends only on the registered count, never on same-cycle mem_ack.
  assign bus.in_ready = (w_count != CW'(FIFO_DEPTH));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_packed     = pack_cmd(bus.fields);

  // The word being written stays in the FIFO until acked, so count includes it.
  assign w_pop = (r_state == W_REQ) && bus.mem_ack;

`ifdef CMD_EMIT_CHECK_EN
  logic w_illegal;
  logic r_err;

  assign w_illegal = cmd_is_illegal(bus.fields);
  assign w_push    = w_accept && !w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;            // clear wins over a same-cycle new error
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused_err_clr;

  assign w_push           = w_accept;
  assign bus.err          = 1'b0;
  assign w_unused_err_clr = bus.err_clr;
`endif

  cmd_emit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_WORD_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_packed),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count)
  );

  // A load while idle applies to the very next write, including one launched
  // on the same edge.
  assign w_launch_addr = bus.addr_load ? bus.addr_base : r_wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= W_IDLE;
      r_wptr     <= '0;
      r_words    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        W_IDLE: begin
          r_wptr <= w_launch_addr;
          if (w_count != '0) begin
            r_mem_data <= w_head;
            r_mem_addr <= w_launch_addr;
            r_state    <= W_REQ;
          end
        end
        W_REQ: begin
          // Address and data hold until acked; addr_load is ignored here.
          if (bus.mem_ack) begin
            r_wptr  <= r_wptr + ADDR_WIDTH'(1);
            r_words <= r_words + ADDR_WIDTH'(1);
            if (w_count > CW'(1)) begin
              // Next word is already buffered: back-to-back writes.
              r_mem_data <= w_next;
              r_mem_addr <= r_wptr + ADDR_WIDTH'(1);
            end else begin
              r_state <= W_IDLE;
            end
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

  assign bus.mem_wr        = (r_state == W_REQ);
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_data      = r_mem_data;
  assign bus.words_written = r_words;
  assign bus.busy          = (w_count != '0) || (r_state == W_REQ);

endmodule

// File: tb/tb_command_word_emit.sv
module tb_command_word_emit;
  import command_word_emit_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  command_word_emit_if #(.ADDR_WIDTH(16)) bus ();

  command_word_emit #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_wptr  = 16'h0;
  logic [15:0] model_words = 16'h0;
  logic        model_err   = 1'b0;
  int          ack_pct     = 100;
  int          wr_cycles   = 0;
  logic [15:0] last_addr   = 16'h0;
  logic [31:0] last_data   = 32'h0;
  int          n_sent      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Reference encoding written straight from the field layout, MSB first.
  function automatic logic [31:0] model_word(input cmd_fields_t f);
    return {f.cmd_code, 2'b00, f.is_cond_true, f.is_cond,
            f.flg_cnd, f.flg_d, f.flg_s0, f.flg_s1,
            f.ptr_cnd, f.reg_cnd, f.ptr_d, f.reg_d,
            f.ptr_s0, f.reg_s0, f.ptr_s1, f.reg_s1};
  endfunction

  function automatic bit model_rejects(input cmd_fields_t f);
`ifdef CMD_EMIT_CHECK_EN
    if (f.is_cond_true && !f.is_cond) return 1'b1;
    if (f.is_cond && !f.ptr_cnd && f.reg_cnd == 3'd0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input cmd_fields_t f);
    int   waited = 0;
    exp_t e;
    bus.fields   = f;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL send_timeout in_ready stayed %b required 1", bus.in_ready);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (bus.err_clr) model_err = 1'b0;
    else if (model_rejects(f)) model_err = 1'b1;
    if (!model_rejects(f)) begin
      e.addr = model_wptr;
      e.data = model_word(f);
      exp_q.push_back(e);
      model_wptr = model_wptr + 16'd1;
    end
    n_sent++;
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (bus.busy || exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL drain_timeout busy=%b pending=%0d required 0", bus.busy, exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic load_addr(input logic [15:0] base);
    bus.addr_base = base;
    bus.addr_load = 1'b1;
    @(posedge clk);
    model_wptr = base;
    #1 bus.addr_load = 1'b0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    @(posedge clk);
    model_err = 1'b0;
    #1 bus.err_clr = 1'b0;
  endtask

  function automatic cmd_fields_t rand_fields();
    logic [31:0] r;
    r = $urandom;
    return cmd_fields_t'(r[$bits(cmd_fields_t)-1:0]);
  endfunction

  // Memory acknowledge driver.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.mem_ack = ($urandom_range(99) < ack_pct);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        hold = 1'b0;
    logic [15:0] h_addr;
    logic [31:0] h_data;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        continue;
      end
      check("busy", bus.busy, exp_q.size() != 0);
      check("in_ready", bus.in_ready, exp_q.size() < DEPTH);
      check("words_written", bus.words_written, model_words);
      check("err", bus.err, model_err);
      if (hold) begin
        check("hold_wr", bus.mem_wr, 1'b1);
        check("hold_addr", bus.mem_addr, h_addr);
        check("hold_data", bus.mem_data, h_data);
      end
      hold = 1'b0;
      if (bus.mem_wr) begin
        wr_cycles++;
        if (bus.mem_ack) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write addr=%h data=%h required no write", bus.mem_addr, bus.mem_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.mem_addr, e.addr);
            check("wr_data", bus.mem_data, e.data);
            model_words = model_words + 16'd1;
          end
          last_addr = bus.mem_addr;
          last_data = bus.mem_data;
        end else begin
          hold   = 1'b1;
          h_addr = bus.mem_addr;
          h_data = bus.mem_data;
        end
      end
    end
  end

  initial begin
    cmd_fields_t f;
    bus.in_valid  = 1'b0;
    bus.fields    = '0;
    bus.addr_load = 1'b0;
    bus.addr_base = '0;
    bus.err_clr   = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_mem_wr", bus.mem_wr, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_data", bus.mem_data, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_words", bus.words_written, 16'h0);
    check("rst_err", bus.err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Single word, acked immediately.
    ack_pct = 100;
    load_addr(16'h0100);
    wr_cycles = 0;
    f = '0; f.reg_s1 = 3'd1; f.reg_s0 = 3'd2; f.reg_d = 3'd3; f.cmd_code = 4'hA;
    send(f);
    wait_drain();
    check("t1_data", last_data, 32'hA0000321);
    check("t1_addr", last_addr, 16'h0100);
    check("t1_wr_cycles", wr_cycles, 1);
    check("t1_words", bus.words_written, 16'd1);

    // 2. Stall: five offered while memory holds off.
    load_addr(16'h0100);
    ack_pct = 0;
    n_sent = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(rand_fields());
      end
      begin
        repeat (8) @(negedge clk);
        check("t2_accepted", n_sent, 4);
        check("t2_in_ready", bus.in_ready, 1'b0);
        check("t2_mem_wr", bus.mem_wr, 1'b1);
        check("t2_mem_addr", bus.mem_addr, 16'h0100);
        ack_pct = 100;
      end
    join
    wait_drain();
    check("t2_last_addr", last_addr, 16'h0104);

    // 3. Address wrap.
    load_addr(16'hFFFF);
    send(rand_fields());
    send(rand_fields());
    wait_drain();
    check("t3_wrap_addr", last_addr, 16'h0000);

    // 4. All-ones fields.
    f = '1;
    send(f);
    wait_drain();
    check("t4_all_ones", last_data, 32'hF3FFFFFF);

    // Randomized traffic with varying memory latency.
    for (int blk = 0; blk < 6; blk++) begin
      ack_pct = 20 + $urandom_range(80);
      if (blk % 2 == 1) begin
        wait_drain();
        load_addr(16'($urandom));
      end
      for (int i = 0; i < 25; i++) send(rand_fields());
    end
    ack_pct = 100;
    wait_drain();
`ifdef CMD_EMIT_CHECK_EN
    pulse_err_clr();
`endif

    // 5. Reset while a write is in flight with entries queued.
    ack_pct = 0;
    for (int i = 0; i < 3; i++) send(rand_fields());
    @(posedge clk); #1;
    check("t5_pre_mem_wr", bus.mem_wr, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    model_words = '0;
    model_wptr  = '0;
    model_err   = 1'b0;
    #1;
    check("t5_mem_wr", bus.mem_wr, 1'b0);
    check("t5_busy", bus.busy, 1'b0);
    check("t5_in_ready", bus.in_ready, 1'b1);
    check("t5_words", bus.words_written, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    ack_pct = 100;
    wr_cycles = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_writes", wr_cycles, 0);

    // 6. Condition polarity without a condition.
    wr_cycles = 0;
    f = '0; f.is_cond = 1'b0; f.is_cond_true = 1'b1; f.cmd_code = 4'h5;
    send(f);
    wait_drain();
`ifdef CMD_EMIT_CHECK_EN
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_write", wr_cycles, 0);
    check("t6_err_set", bus.err, 1'b1);
    pulse_err_clr();
    check("t6_err_clr", bus.err, 1'b0);
    f = '0; f.is_cond = 1'b1; f.ptr_cnd = 1'b0; f.reg_cnd = 3'd0;
    send(f);
    check("t6_err_cnd0", bus.err, 1'b1);
    pulse_err_clr();
    bus.err_clr = 1'b1;
    f = '0; f.is_cond_true = 1'b1;
    send(f);
    bus.err_clr = 1'b0;
    check("t6_clr_wins", bus.err, 1'b0);
    f = '0; f.is_cond = 1'b1; f.reg_cnd = 3'd1; f.cmd_code = 4'h3;
    send(f);
    wait_drain();
    check("t6_legal_cond", last_data[24], 1'b1);
`else
    check("t6_bit25", last_data[25], 1'b1);
    check("t6_written", wr_cycles, 1);
    check("t6_err_tied", bus.err, 1'b0);
`endif

    wait_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
